// File: rtl/mem_access_seq.sv
// mem_access_seq: memory-access sequencer between the multi-cycle controller
// and a single-ported, variable-latency memory bus. It turns the controller's
// MemRead/MemWrite strobes into a req/ack bus transaction, loads the IR or
// MDR with read data, and holds the controller via stall until the access is
// complete. A bus that never acknowledges is abandoned after TIMEOUT request
// cycles, and the sticky bus_err flag is raised.
//
// Optional feature: define MEM_ALIGN_CHECK_EN to reject misaligned accesses.
// A rejected access never reaches the bus and sets the sticky misalign flag.
// When the macro is not defined, misalign is tied to 0 and the low two
// address bits are dropped on the bus.
module mem_access_seq #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              IorD,
  input  logic              IRWrite,
  input  logic [31:0]       pc,
  input  logic [31:0]       alu_out,
  input  logic [31:0]       wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       ir,
  output logic [31:0]       mdr,
  output logic              stall,
  output logic              bus_err,
  output logic              misalign
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_t;

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

  state_t           state;
  logic             tgt_ir;
  logic [CNT_W-1:0] count;
  logic             access_start;
  logic [31:0]      sel_addr;

  assign access_start = MemRead | MemWrite;
  assign sel_addr     = IorD ? alu_out : pc;

`ifdef MEM_ALIGN_CHECK_EN
  logic misaligned_req;
  assign misaligned_req = (sel_addr[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  // Sequencer FSM: capture the request in IDLE, hold the bus in REQ until ack
  // or timeout, and spend one DONE cycle releasing the controller.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ir        <= '0;
      mdr       <= '0;
      bus_err   <= 1'b0;
      tgt_ir    <= 1'b0;
      count     <= '0;
`ifdef MEM_ALIGN_CHECK_EN
      misalign  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (access_start) begin
`ifdef MEM_ALIGN_CHECK_EN
            if (misaligned_req) begin
              misalign <= 1'b1;
              state    <= DONE;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= MemWrite;
              mem_addr  <= sel_addr[ADDR_W-1:0] & WORD_MASK;
              mem_wdata <= wdata;
              tgt_ir    <= IRWrite & ~MemWrite;
              count     <= '0;
              state     <= REQ;
            end
`else
            mem_req   <= 1'b1;
            mem_we    <= MemWrite;
            mem_addr  <= sel_addr[ADDR_W-1:0] & WORD_MASK;
            mem_wdata <= wdata;
            tgt_ir    <= IRWrite & ~MemWrite;
            count     <= '0;
            state     <= REQ;
`endif
          end
        end
        REQ: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (!mem_we) begin
              if (tgt_ir) ir  <= mem_rdata;
              else        mdr <= mem_rdata;
            end
            state <= DONE;
          end else if (count == CNT_LAST) begin
            mem_req <= 1'b0;
            bus_err <= 1'b1;
            state   <= DONE;
          end else begin
            count <= count + 1'b1;
          end
        end
        DONE: begin
          count <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stall is combinational so the controller freezes in the same cycle the
  // strobe is first seen; it is forced low while reset is asserted.
  always_comb begin
    stall = 1'b0;
    if (!rst) begin
      case (state)
        IDLE:    stall = access_start;
        REQ:     stall = 1'b1;
        default: stall = 1'b0;
      endcase
    end
  end

endmodule
